// File: rtl/conware_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conware_gen_ctrl
// Purpose  : Generation sequencer for the Game-of-Life pipeline. Each
//            generation loads a frame from the input buffer (skipped after the
//            first generation in feedback mode), pulses the compute core, waits
//            for it, then stores the result through the output serializer.
//            A watchdog aborts any wait phase that stalls too long.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   start, abort     run control (abort wins over start)
//   num_gens         generations per run (0 = free-run), latched on start
//   feedback         reuse compute output after generation 1, latched on start
//   ld_req/ld_valid  input buffer handshake
//   comp_start/done  compute core pulse / completion
//   sel_feedback     compute source: 0 = input buffer, 1 = previous result
//   st_req/st_done   output serializer handshake
//   busy, done       status (done = one-cycle end-of-run pulse)
//   timeout          sticky watchdog flag, cleared on an accepted start
//   gen_count        generations completed in the current run
//   state_dbg        raw state encoding
// ============================================================================
module conware_gen_ctrl #(
  parameter int GEN_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [GEN_WIDTH-1:0] num_gens,
  input  logic                 feedback,
  output logic                 ld_req,
  input  logic                 ld_valid,
  output logic                 comp_start,
  input  logic                 comp_done,
  output logic                 sel_feedback,
  output logic                 st_req,
  input  logic                 st_done,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [GEN_WIDTH-1:0] gen_count,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CSTART = 3'd2,
    ST_CWAIT  = 3'd3,
    ST_STORE  = 3'd4,
    ST_NEXT   = 3'd5
  } state_t;

  localparam bit                c_WD_EN   = (TIMEOUT_CYCLES != 0);
  // The watchdog fires on the last permitted wait cycle so that the abort
  // edge lands exactly TIMEOUT_CYCLES cycles after the wait state was entered.
  localparam logic [TO_WIDTH-1:0] c_WD_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [GEN_WIDTH-1:0]   r_num_gens;
  logic                   r_feedback;
  logic [TO_WIDTH-1:0]    r_wd;
  logic [GEN_WIDTH-1:0]   r_gen_count;
  logic                   r_sel;
  logic                   r_ld_req;
  logic                   r_comp_start;
  logic                   r_st_req;
  logic                   r_done;
  logic                   r_timeout;

  logic                   w_wait_state;
  logic                   w_wd_expire;
  logic [GEN_WIDTH-1:0]   w_gen_inc;
  logic                   w_inc_is_last;
  logic                   w_run_complete;
  logic                   w_accept;
  logic                   w_timeout_fire;
  logic                   w_enter_next;

  assign w_wait_state   = (r_state == ST_LOAD) || (r_state == ST_CWAIT) ||
                          (r_state == ST_STORE);
  assign w_wd_expire    = c_WD_EN && w_wait_state && (r_wd == c_WD_LAST);
  assign w_gen_inc      = r_gen_count + GEN_WIDTH'(1);
  // Evaluated while leaving STORE: will the increment finish the run?
  assign w_inc_is_last  = (r_num_gens != '0) && (w_gen_inc == r_num_gens);
  // Evaluated in NEXT, where gen_count already holds the incremented value.
  assign w_run_complete = (r_num_gens != '0) && (r_gen_count == r_num_gens);
  assign w_enter_next   = (r_state == ST_STORE) && (w_state_nxt == ST_NEXT);

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_timeout_fire = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_LOAD;
            w_accept    = 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            w_state_nxt = ST_CSTART;
          end else if (w_wd_expire) begin
            w_state_nxt    = ST_IDLE;
            w_timeout_fire = 1'b1;
          end
        end
        // comp_done is deliberately not looked at here: a level left over
        // from the previous generation must not complete this one.
        ST_CSTART: w_state_nxt = ST_CWAIT;
        ST_CWAIT: begin
          if (comp_done) begin
            w_state_nxt = ST_STORE;
          end else if (w_wd_expire) begin
            w_state_nxt    = ST_IDLE;
            w_timeout_fire = 1'b1;
          end
        end
        ST_STORE: begin
          if (st_done) begin
            w_state_nxt = ST_NEXT;
          end else if (w_wd_expire) begin
            w_state_nxt    = ST_IDLE;
            w_timeout_fire = 1'b1;
          end
        end
        ST_NEXT: begin
          if (w_run_complete) begin
            w_state_nxt = ST_IDLE;
          end else if (r_feedback) begin
            w_state_nxt = ST_CSTART;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_num_gens   <= '0;
      r_feedback   <= 1'b0;
      r_wd         <= '0;
      r_gen_count  <= '0;
      r_sel        <= 1'b0;
      r_ld_req     <= 1'b0;
      r_comp_start <= 1'b0;
      r_st_req     <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // Request outputs are registered from the next state so they are
      // exactly aligned with the state they belong to.
      r_ld_req     <= (w_state_nxt == ST_LOAD);
      r_comp_start <= (w_state_nxt == ST_CSTART);
      r_st_req     <= (w_state_nxt == ST_STORE);
      r_done       <= (w_enter_next && w_inc_is_last) || w_timeout_fire;

      if (w_state_nxt != r_state) begin
        r_wd <= '0;
      end else if (w_wait_state) begin
        r_wd <= r_wd + TO_WIDTH'(1);
      end

      if (w_accept) begin
        r_num_gens  <= num_gens;
        r_feedback  <= feedback;
        r_gen_count <= '0;
        r_timeout   <= 1'b0;
        r_sel       <= 1'b0;
      end

      // The increment is taken on the edge into NEXT so that gen_count and
      // done are both valid during the NEXT cycle.
      if (w_enter_next) begin
        r_gen_count <= w_gen_inc;
        if (r_feedback && !w_inc_is_last) begin
          r_sel <= 1'b1;
        end
      end

      if (w_timeout_fire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign ld_req       = r_ld_req;
  assign comp_start   = r_comp_start;
  assign st_req       = r_st_req;
  assign sel_feedback = r_sel;
  assign done         = r_done;
  assign timeout      = r_timeout;
  assign gen_count    = r_gen_count;
  assign busy         = (r_state != ST_IDLE);
  assign state_dbg    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_conware_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conware_gen_ctrl
// Purpose  : Self-checking bench for conware_gen_ctrl. A phase-level model
//            builds a per-cycle script of expected outputs and the handshake
//            inputs to drive; the script is then replayed against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conware_gen_ctrl;

  localparam int TO = 20;

  logic        clk;
  logic        rstn, start, abort, feedback;
  logic [31:0] num_gens;
  logic        ld_req, ld_valid, comp_start, comp_done, sel_feedback;
  logic        st_req, st_done, busy, done, timeout;
  logic [31:0] gen_count;
  logic [2:0]  state_dbg;

  conware_gen_ctrl #(
    .GEN_WIDTH      (32),
    .TIMEOUT_CYCLES (TO),
    .TO_WIDTH       (5)
  ) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .abort        (abort),
    .num_gens     (num_gens),
    .feedback     (feedback),
    .ld_req       (ld_req),
    .ld_valid     (ld_valid),
    .comp_start   (comp_start),
    .comp_done    (comp_done),
    .sel_feedback (sel_feedback),
    .st_req       (st_req),
    .st_done      (st_done),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .gen_count    (gen_count),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] w_obs;
  assign w_obs = {busy, state_dbg, ld_req, comp_start, st_req, sel_feedback, done, timeout};

  // One script step: what the outputs must be this cycle, and what to drive
  // for the coming edge.
  typedef struct packed {
    logic [7:0]  sc;
    logic [9:0]  vec;
    logic [31:0] gc;
    logic        rstn_d, start_d, abort_d, ldv, cd, sd, fb;
    logic [31:0] ng;
  } step_t;

  step_t       q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Model state: what the run looks like from the outside.
  logic [31:0] m_gc = 0;
  logic [31:0] m_n  = 0;
  bit          m_fb = 0, m_sel = 0, m_to = 0, m_stale = 0;
  logic [7:0]  m_sc = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic step_t mk(input int st, input bit ldr, input bit cs, input bit sr, input bit dn);
    step_t e;
    e.sc      = m_sc;
    e.vec     = {(st != 0), 3'(st), ldr, cs, sr, m_sel, dn, m_to};
    e.gc      = m_gc;
    e.rstn_d  = 1'b1;
    e.start_d = 1'b0;
    e.abort_d = 1'b0;
    e.ldv     = 1'b0;
    e.cd      = m_stale;
    e.sd      = 1'b0;
    e.fb      = 1'($urandom_range(0, 1));  // junk: must only matter on start
    e.ng      = $urandom;
    return e;
  endfunction

  task automatic push_idle(input int n);
    repeat (n) q.push_back(mk(0, 0, 0, 0, 0));
  endtask

  task automatic push_start(input int n, input bit fb, input bit ab);
    step_t e = mk(0, 0, 0, 0, 0);
    e.start_d = 1'b1; e.abort_d = ab; e.ng = n; e.fb = fb;
    q.push_back(e);
    if (!ab) begin
      m_gc = 0; m_sel = 0; m_to = 0; m_n = n; m_fb = fb;
    end
  endtask

  task automatic ph_load(input int d);
    for (int i = 0; i <= d; i++) begin
      step_t e = mk(1, 1, 0, 0, 0);
      e.ldv = (i == d);
      q.push_back(e);
    end
  endtask

  task automatic ph_cstart();
    q.push_back(mk(2, 0, 1, 0, 0));
  endtask

  task automatic ph_cwait(input int d);
    for (int i = 0; i <= d; i++) begin
      step_t e = mk(3, 0, 0, 0, 0);
      e.cd = m_stale || (i == d);
      q.push_back(e);
    end
  endtask

  task automatic ph_store(input int d);
    for (int i = 0; i <= d; i++) begin
      step_t e = mk(4, 0, 0, 1, 0);
      e.sd = (i == d);
      q.push_back(e);
    end
  endtask

  task automatic ph_next(output bit last);
    m_gc = m_gc + 1;
    last = (m_n != 0) && (m_gc == m_n);
    if (!last && m_fb) m_sel = 1;
    q.push_back(mk(5, 0, 0, 0, last));
  endtask

  task automatic run_gens(input int count, input int dmax);
    bit last;
    for (int g = 0; g < count; g++) begin
      if (!m_fb || m_gc == 0) ph_load($urandom_range(0, dmax));
      ph_cstart();
      ph_cwait(m_stale ? 0 : $urandom_range(0, dmax));
      ph_store($urandom_range(0, dmax));
      ph_next(last);
    end
  endtask

  // Wait phase that never gets answered: expires after TO cycles, then one
  // IDLE cycle carrying done and the freshly set timeout flag.
  task automatic ph_stall(input int st);
    for (int i = 0; i < TO; i++) q.push_back(mk(st, st == 1, 0, st == 4, 0));
    m_to = 1;
    q.push_back(mk(0, 0, 0, 0, 1));
  endtask

  task automatic build_script();
    step_t e;
    bit    last;
    // 0: reset state, released on the first step
    m_sc = 0; push_idle(2);
    // 1: single generation, every handshake answered 2 cycles late
    m_sc = 1; push_start(1, 0, 0);
    ph_load(2); ph_cstart(); ph_cwait(2); ph_store(2); ph_next(last);
    push_idle(2);
    // 2: feedback run of three generations
    m_sc = 2; push_start(3, 1, 0); run_gens(3, 3); push_idle(2);
    // 3: free-run, ten generations, then abort in CWAIT of the eleventh
    m_sc = 3; push_start(0, 0, 0); run_gens(10, 2);
    ph_load(1); ph_cstart();
    e = mk(3, 0, 0, 0, 0); e.abort_d = 1'b1; q.push_back(e);
    push_idle(4);
    // 4: watchdog in CWAIT
    m_sc = 4; push_start(2, 0, 0); ph_load(1); ph_cstart(); ph_stall(3); push_idle(2);
    // 5: start+abort together: stays idle, timeout still held
    m_sc = 5; push_start(5, 1, 1); push_idle(2);
    // 6: next start clears timeout; compute answers on the last legal cycle
    m_sc = 6; push_start(1, 0, 0);
    ph_load(0); ph_cstart(); ph_cwait(TO - 1); ph_store(0); ph_next(last);
    push_idle(2);
    // 7: watchdog in LOAD, then reset while idle clears timeout
    m_sc = 7; push_start(3, 1, 0); ph_stall(1); push_idle(1);
    e = mk(0, 0, 0, 0, 0); e.rstn_d = 1'b0; q.push_back(e);
    m_gc = 0; m_sel = 0; m_to = 0; push_idle(2);
    // 8: stale comp_done level never shortcuts CSTART/CWAIT
    m_sc = 8; m_stale = 1; push_start(3, 1, 0); run_gens(3, 2);
    push_start(2, 0, 0); run_gens(2, 1); m_stale = 0; push_idle(2);
    // 9: reset in STORE drops the run silently
    m_sc = 9; push_start(2, 1, 0); run_gens(1, 1);
    ph_cstart(); ph_cwait(1);
    e = mk(4, 0, 0, 1, 0); e.rstn_d = 1'b0; q.push_back(e);
    m_gc = 0; m_sel = 0; m_to = 0; push_idle(2);
    // 10+: random runs
    for (int r = 0; r < 6; r++) begin
      m_sc = 8'(10 + r);
      push_start($urandom_range(1, 4), 1'($urandom_range(0, 1)), 0);
      run_gens(int'(m_n), 4);
      push_idle($urandom_range(1, 2));
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; feedback = 1'b0; num_gens = '0;
    ld_valid = 1'b0; comp_done = 1'b0; st_done = 1'b0;
    build_script();
    repeat (3) @(posedge clk);
    for (int i = 0; i < q.size(); i++) begin
      step_t e = q[i];
      @(negedge clk);
      check_val($sformatf("sc%0d.c%0d.out", e.sc, i), 32'(w_obs), 32'(e.vec));
      check_val($sformatf("sc%0d.c%0d.gen", e.sc, i), gen_count, e.gc);
      rstn      = e.rstn_d;
      start     = e.start_d;
      abort     = e.abort_d;
      num_gens  = e.ng;
      feedback  = e.fb;
      ld_valid  = e.ldv;
      comp_done = e.cd;
      st_done   = e.sd;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conware_gen_ctrl.md
Name: conware_gen_ctrl

Overview:
- Generation sequencer for the Game-of-Life pipeline.
- Steps each generation through three phases: load a frame from the AXIS-to-bitmap input buffer, run the neighbour-compute core, then store the result through the output serializer.
- Counts generations, supports a feedback mode that skips reloading after the first generation, and has a watchdog so a stalled stage cannot hang the pipeline.

Parameters:
- GEN_WIDTH, 32, width of the generation count and limit.
- TIMEOUT_CYCLES, 65535, maximum cycles spent in any wait state before abort; 0 disables the watchdog.
- TO_WIDTH, 16, width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2^TO_WIDTH.

Ports:
- clk  input  1  system clock.
- rstn  input  1  synchronous active-low reset.
- start  input  1  begins a run when sampled high in IDLE; ignored otherwise.
- abort  input  1  forces return to IDLE from any state.
- num_gens  input  GEN_WIDTH  generations per run; 0 = free-run until abort; sampled on start.
- feedback  input  1  1 = generations after the first reuse compute output; sampled on start.
- ld_req  output  1  drives the input buffer's out_ready; high only in LOAD.
- ld_valid  input  1  input buffer has a complete frame.
- comp_start  output  1  single-cycle pulse to the compute core.
- comp_done  input  1  compute core finished; level or pulse.
- sel_feedback  output  1  compute source select: 0 = input buffer, 1 = previous result.
- st_req  output  1  output serializer request; held high in STORE.
- st_done  input  1  serializer finished emitting the frame.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse at end of run.
- timeout  output  1  sticky; set on watchdog expiry, cleared on accepted start.
- gen_count  output  GEN_WIDTH  generations completed in the current run.
- state_dbg  output  3  state encoding.

Behaviour:
- Clocking and reset: all state is updated on the rising edge of clk.
- Reset (rstn=0): state=IDLE; all outputs 0; internal latched num_gens, feedback and watchdog counter cleared. Reset mid-run drops the run silently, with no done pulse.
- State encoding: IDLE=0, LOAD=1, CSTART=2, CWAIT=3, STORE=4, NEXT=5.
- IDLE:
  - start=1 latches num_gens and feedback, clears gen_count, timeout and sel_feedback, then goes to LOAD.
  - If start and abort are both high, abort wins and the controller stays in IDLE.
- LOAD:
  - ld_req=1.
  - ld_valid=1 → CSTART. ld_req is deasserted the cycle after ld_valid is seen.
- CSTART:
  - comp_start=1 for exactly one cycle, then CWAIT.
- CWAIT:
  - comp_done=1 → STORE.
  - comp_done is ignored on the CSTART cycle, so a stale level from the previous generation cannot complete early.
- STORE:
  - st_req=1 until st_done=1, then NEXT.
- NEXT (one cycle):
  - gen_count increments, wrapping at 2^GEN_WIDTH.
  - If num_gens≠0 and the new gen_count == num_gens: done=1 for this cycle, then IDLE.
  - Otherwise, if feedback=1: sel_feedback←1, go to CSTART (LOAD skipped).
  - Otherwise go to LOAD.
- sel_feedback is stable from NEXT through CWAIT of the following generation.
- Watchdog:
  - The counter resets on every state entry and counts in LOAD, CWAIT and STORE.
  - When it reaches TIMEOUT_CYCLES: timeout←1, done=1 for one cycle, next state IDLE, gen_count held.
- abort:
  - Any state goes to IDLE the next cycle, with no done pulse.
  - All request outputs drop on that edge; gen_count is held for readback.
- Minimum latency per generation: without feedback, LOAD entry to NEXT exit is 5 cycles when each handshake is answered immediately. With feedback it is 4 cycles.
- Output registering: outputs are registered, except busy and state_dbg, which decode directly from the state register.

Test Plan:
- Single generation: num_gens=1, feedback=0, ld_valid/comp_done/st_done each answered 2 cycles after request.
  - Required: ld_req, then comp_start pulse, then st_req. done pulses once, gen_count=1, returns to IDLE, busy low.
- Feedback run: num_gens=3, feedback=1.
  - Required: exactly one LOAD phase and three comp_start pulses.
  - sel_feedback=0 for generation 1 and 1 for generations 2–3; gen_count=3 at done.
- Free-run: num_gens=0, feedback=0, run 10 generations, then assert abort in CWAIT.
  - Required: IDLE next cycle, no done pulse, gen_count=10, comp_start never pulses again.
- Watchdog: TIMEOUT_CYCLES=20, comp_done held low.
  - Required: 20 cycles after CWAIT entry, timeout=1 and done pulses; timeout clears on the next start.
- Stale done: comp_done tied high.
  - Required: each generation still spends ≥1 cycle in CWAIT after comp_start; no generation skips CSTART.
- Reset and start races:
  - rstn low during STORE: all outputs 0 next cycle, IDLE.
  - start and abort both high in IDLE: remains IDLE, busy=0.
